trigger_power_detect: RTL and testbench

TRIGGER_POWER_DETECT -- requirements
Module: trigger_power_detect

---
 rtl/trigger_pkg.sv | 27 ++
 rtl/power_sum8.sv | 48 ++++
 rtl/trigger_power_detect.sv | 107 ++++++++++
 tb/tb_trigger_power_detect.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trigger_pkg.sv
// rtl/trigger_pkg.sv - shared constants, FSM states and sample helpers for the power trigger
package trigger_pkg;

  localparam int NSAMP = 8;
  localparam int NBITS = 12;
  localparam int SQ_W  = 23;
  localparam int PWR_W = 26;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_HOLDOFF  = 2'd2
  } trig_state_e;

  // Sample k of the packed bus, k=0 is the oldest sample.
  function automatic logic [NBITS-1:0] get_sample(input logic [NSAMP*NBITS-1:0] bus, input int k);
    return bus[k*NBITS +: NBITS];
  endfunction

  // Square via magnitude so -2048 squares to 4194304 inside 23 unsigned bits.
  function automatic logic [SQ_W-1:0] square_sample(input logic [NBITS-1:0] s);
    logic [NBITS-1:0] mag;
    mag = s[NBITS-1] ? (~s + 1'b1) : s;
    return SQ_W'(mag) * SQ_W'(mag);
  endfunction

endpackage

// File: rtl/power_sum8.sv
// rtl/power_sum8.sv - two-stage square-and-sum pipeline producing per-clock power
module power_sum8 #(
  parameter int NSAMP = trigger_pkg::NSAMP,
  parameter int NBITS = trigger_pkg::NBITS
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NSAMP*NBITS-1:0]        dat_i,
  output logic [trigger_pkg::PWR_W-1:0] power_o
);
  import trigger_pkg::*;

  logic [SQ_W-1:0]  sq_d [NSAMP];
  logic [SQ_W-1:0]  sq_q [NSAMP];
  logic [PWR_W-1:0] power_d;
  logic [PWR_W-1:0] power_q;

  // Stage 1 combinational: square every sample of the incoming word.
  always_comb begin
    for (int k = 0; k < NSAMP; k++) begin
      sq_d[k] = square_sample(get_sample(dat_i, k));
    end
  end

  // Stage 2 combinational: the sum of eight 23-bit squares always fits 26 bits.
  always_comb begin
    power_d = '0;
    for (int k = 0; k < NSAMP; k++) begin
      power_d = power_d + PWR_W'(sq_q[k]);
    end
  end

  // Pipeline registers; they run regardless of the trigger state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NSAMP; k++) begin
        sq_q[k] <= '0;
      end
      power_q <= '0;
    end else begin
      sq_q    <= sq_d;
      power_q <= power_d;
    end
  end

  assign power_o = power_q;

endmodule

// File: rtl/trigger_power_detect.sv
// rtl/trigger_power_detect.sv - power threshold trigger with holdoff FSM; TRIG_POWER_SCALER_EN adds the trigger scaler
module trigger_power_detect #(
  parameter int NSAMP  = trigger_pkg::NSAMP,
  parameter int NBITS  = trigger_pkg::NBITS,
  parameter int HOLD_W = 16
) (
  input  logic                          aclk,
  input  logic                          reset_i,
  input  logic [NSAMP*NBITS-1:0]        dat_i,
  input  logic [trigger_pkg::PWR_W-1:0] thresh_i,
  input  logic [HOLD_W-1:0]             holdoff_i,
  input  logic                          arm_i,
  input  logic                          disarm_i,
  input  logic                          scaler_clr_i,
  output logic                          trig_o,
  output logic                          armed_o,
  output logic [trigger_pkg::PWR_W-1:0] power_o,
  output logic [31:0]                   trig_count_o
);
  import trigger_pkg::*;

  trig_state_e       state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              trig_q, trig_d;
  logic [PWR_W-1:0]  power;
  logic              hit;

  power_sum8 #(
    .NSAMP(NSAMP),
    .NBITS(NBITS)
  ) u_power_sum8 (
    .clk_i  (aclk),
    .rst_i  (reset_i),
    .dat_i  (dat_i),
    .power_o(power)
  );

  // Equal power must not trigger.
  assign hit = power > thresh_i;

  // Next state: disarm beats everything, arm only matters from DISARMED.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    trig_d  = 1'b0;
    if (disarm_i) begin
      state_d = ST_DISARMED;
    end else begin
      case (state_q)
        ST_DISARMED: begin
          if (arm_i) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (hit) begin
            state_d = ST_HOLDOFF;
            cnt_d   = holdoff_i;
            trig_d  = 1'b1;
          end
        end
        ST_HOLDOFF: begin
          if (cnt_q == '0) state_d = ST_ARMED;
          else             cnt_d   = cnt_q - 1'b1;
        end
        default: state_d = ST_DISARMED;
      endcase
    end
  end

  // State, holdoff counter and registered trigger pulse.
  always_ff @(posedge aclk or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_DISARMED;
      cnt_q   <= '0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      trig_q  <= trig_d;
    end
  end

  assign trig_o  = trig_q;
  assign armed_o = (state_q == ST_ARMED);
  assign power_o = power;

`ifdef TRIG_POWER_SCALER_EN
  logic [31:0] trig_count_q;

  // Scaler counts each trigger pulse as it is issued; clear has priority.
  always_ff @(posedge aclk or posedge reset_i) begin
    if (reset_i) begin
      trig_count_q <= '0;
    end else if (scaler_clr_i) begin
      trig_count_q <= '0;
    end else if (trig_d) begin
      trig_count_q <= trig_count_q + 32'd1;
    end
  end

  assign trig_count_o = trig_count_q;
`else
  logic unused_scaler_clr;
  assign unused_scaler_clr = scaler_clr_i;
  assign trig_count_o      = '0;
`endif

endmodule

// File: tb/tb_trigger_power_detect.sv
// tb/tb_trigger_power_detect.sv - self-checking bench for trigger_power_detect
module tb_trigger_power_detect;

  logic        aclk = 1'b0;
  logic        reset_i;
  logic [95:0] dat;
  logic [25:0] thresh;
  logic [15:0] holdoff;
  logic        arm, disarm, clr;
  logic        trig_o, armed_o;
  logic [25:0] power_o;
  logic [31:0] trig_count_o;

  int checks   = 0;
  int failures = 0;

  // reference model state (time-based view of the trigger rules)
  longint      m_edge;
  bit          m_en;
  longint      m_ready;
  longint      m_power, m_pending;
  bit          m_trig, m_armed;
  logic [31:0] m_count;

  localparam logic [95:0] HOT  = {8{12'h800}};
  localparam logic [95:0] COLD = '0;
  localparam logic [95:0] H100 = {8{12'h064}};

  typedef struct {
    logic [95:0] dat;
    longint      exp_pwr;
  } vec_t;

  vec_t vecs[7];

  trigger_power_detect dut (
    .aclk        (aclk),
    .reset_i     (reset_i),
    .dat_i       (dat),
    .thresh_i    (thresh),
    .holdoff_i   (holdoff),
    .arm_i       (arm),
    .disarm_i    (disarm),
    .scaler_clr_i(clr),
    .trig_o      (trig_o),
    .armed_o     (armed_o),
    .power_o     (power_o),
    .trig_count_o(trig_count_o)
  );

  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic longint pwr_of(input logic [95:0] d);
    logic [11:0] t;
    int          v;
    longint      s;
    s = 0;
    for (int k = 0; k < 8; k++) begin
      t = d[k*12 +: 12];
      v = int'($signed(t));
      s += longint'(v) * longint'(v);
    end
    return s;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_en      = 0;
    m_ready   = 0;
    m_power   = 0;
    m_pending = 0;
    m_trig    = 0;
    m_armed   = 0;
    m_count   = '0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_trig"},  longint'(trig_o),       longint'(m_trig));
    chk({tag, "_armed"}, longint'(armed_o),      longint'(m_armed));
    chk({tag, "_power"}, longint'(power_o),      m_power);
    chk({tag, "_count"}, longint'(trig_count_o), longint'(m_count));
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic step();
    bit t;
    @(posedge aclk);
    t = 0;
    if (disarm) begin
      m_en = 0;
    end else if (!m_en) begin
      if (arm) begin
        m_en    = 1;
        m_ready = m_edge + 1;
      end
    end else if (m_edge >= m_ready && m_power > longint'(thresh)) begin
      t       = 1;
      m_ready = m_edge + longint'(holdoff) + 2;
    end
    m_trig    = t;
    m_power   = m_pending;
    m_pending = pwr_of(dat);
`ifdef TRIG_POWER_SCALER_EN
    if (clr)    m_count = '0;
    else if (t) m_count = m_count + 32'd1;
`endif
    m_armed = m_en && (m_edge >= m_ready - 1);
    m_edge++;
    #1;
    check_all("step");
  endtask

  task automatic latency_seq(input logic [95:0] d, input logic [25:0] th, input longint pw, input string tag);
    disarm = 1; arm = 0; dat = COLD; thresh = th; holdoff = 0;
    step(); step(); step();
    disarm = 0; arm = 1;
    step();
    arm = 0; dat = d;
    step();
    chk({tag, "_n1_trig"}, longint'(trig_o), 0);
    dat = COLD;
    step();
    chk({tag, "_n2_trig"}, longint'(trig_o), 0);
    chk({tag, "_n2_power"}, longint'(power_o), pw);
    step();
    chk({tag, "_n3_trig"}, longint'(trig_o), 1);
    step();
    chk({tag, "_n4_trig"}, longint'(trig_o), 0);
  endtask

  initial begin
    int pulses;
    int exp5;

    vecs[0] = '{HOT,                          33554432};
    vecs[1] = '{{{7{12'h800}}, 12'h000},      29360128};
    vecs[2] = '{H100,                         80000};
    vecs[3] = '{{8{12'h7FF}},                 33521672};
    vecs[4] = '{{8{12'hFFF}},                 8};
    vecs[5] = '{COLD,                         0};
    vecs[6] = '{{{7{12'h000}}, 12'h001},      1};

    reset_i = 1; dat = HOT; thresh = 0; holdoff = 0; arm = 0; disarm = 0; clr = 0;
    m_edge = 0;
    model_reset();
    #1;
    check_all("reset");
    @(posedge aclk); @(posedge aclk);
    #1;
    check_all("reset_clk");
    reset_i = 0;

    // stale hot data but never armed: no trigger may appear
    for (int i = 0; i < 6; i++) step();
    chk("noarm_trig", longint'(trig_o), 0);

    // table of power vectors
    disarm = 1;
    foreach (vecs[i]) begin
      dat = vecs[i].dat;
      step();
      step();
      chk($sformatf("vec%0d_power", i), longint'(power_o), vecs[i].exp_pwr);
    end

    // strict compare and latency
    disarm = 1; dat = H100; thresh = 26'd80000; holdoff = 0;
    step(); step(); step();
    disarm = 0; arm = 1;
    step();
    arm = 0; pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      pulses += int'(trig_o);
    end
    chk("equal_no_trig", longint'(pulses), 0);
    latency_seq(H100, 26'd79999, 80000, "lat100");
    latency_seq(HOT, 26'd33554431, 33554432, "latmax");

    // holdoff 0, continuous hot data: pulse every 2 clocks
    disarm = 1; clr = 1; dat = HOT; thresh = 0; holdoff = 0; arm = 0;
    step(); step();
    disarm = 0; clr = 0; arm = 1;
    step();
    arm = 0; pulses = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      pulses += int'(trig_o);
    end
    chk("hold0_pulses", longint'(pulses), 5);
`ifdef TRIG_POWER_SCALER_EN
    exp5 = 5;
`else
    exp5 = 0;
`endif
    chk("hold0_count", longint'(trig_count_o), longint'(exp5));
    step();
    clr = 1;
    step();
    chk("clr_vs_trig_trig", longint'(trig_o), 1);
    chk("clr_vs_trig_count", longint'(trig_count_o), 0);
    clr = 0;

    // arm and disarm together on the edge of a hit
    disarm = 1; dat = COLD; thresh = 26'd33554431;
    step(); step(); step();
    disarm = 0; arm = 1;
    step();
    arm = 0; dat = HOT;
    step();
    dat = COLD;
    step();
    arm = 1; disarm = 1;
    step();
    chk("armdis_trig", longint'(trig_o), 0);
    chk("armdis_armed", longint'(armed_o), 0);
    arm = 0; disarm = 0;

    // reset in the middle of a long holdoff
    disarm = 1; dat = HOT; thresh = 0; holdoff = 16'd1000;
    step(); step();
    disarm = 0; arm = 1;
    step();
    arm = 0;
    for (int i = 0; i < 20 && !trig_o; i++) step();
    chk("long_hold_trig", longint'(trig_o), 1);
    for (int i = 0; i < 500; i++) step();
    reset_i = 1;
    #1;
    model_reset();
    check_all("async_reset");
    #2;
    reset_i = 0;
    holdoff = 0;
    for (int i = 0; i < 10; i++) step();
    chk("post_reset_trig", longint'(trig_o), 0);
    arm = 1;
    step();
    arm = 0;
    step();
    chk("rearm_trig", longint'(trig_o), 1);

`ifdef TRIG_POWER_SCALER_EN
    // scaler wrap from all-ones
    disarm = 1;
    step();
    dut.trig_count_q = 32'hFFFF_FFFF;
    m_count = 32'hFFFF_FFFF;
    disarm = 0; arm = 1;
    step();
    arm = 0;
    for (int i = 0; i < 20 && !trig_o; i++) step();
    chk("wrap_trig", longint'(trig_o), 1);
    chk("wrap_count", longint'(trig_count_o), 0);
`endif

    // randomized run against the model
    disarm = 0; arm = 0; clr = 0; holdoff = 0;
    for (int i = 0; i < 2000; i++) begin
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 3) == 0) dat[k*12 +: 12] = 12'h800;
        else                           dat[k*12 +: 12] = 12'($urandom_range(0, 4095));
      end
      if ($urandom_range(0, 49) == 0) thresh = 26'($urandom_range(0, 20000000));
      arm     = ($urandom_range(0, 7) == 0);
      disarm  = ($urandom_range(0, 39) == 0);
      clr     = ($urandom_range(0, 49) == 0);
      holdoff = 16'($urandom_range(0, 6));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
